niosii_onchip_mem_loader: RTL and testbench



---
 rtl/niosii_onchip_mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_niosii_onchip_mem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_onchip_mem_loader.sv
// Byte-stream loader that packs bytes little-endian into 32-bit words and fills on-chip program RAM.
// Optional MEM_LOADER_VERIFY_EN adds a readback pass that compares the sum of stored words to the checksum.
module niosii_onchip_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 12000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    // state | meaning
    // IDLE   | waiting for start
    // FILL   | accepting bytes into the word buffer
    // WRITE  | one-cycle write of the assembled word
    // VERIFY | readback pass (only with MEM_LOADER_VERIFY_EN)
    // DONE   | one-cycle completion pulse
`ifdef MEM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] words_q;
    logic [1:0]        idx_q;
    logic [31:0]       word_q;
    logic [31:0]       checksum_q;
    logic              error_q;
    logic [ADDR_W:0]   end_addr;
    logic              range_err;
    logic              last_word;

    assign end_addr  = {1'b0, base_addr} + {1'b0, word_count};
    assign range_err = end_addr > DEPTH_L;
    assign last_word = (words_q + ADDR_W'(1)) == cnt_q;

`ifdef MEM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] vcnt_q;
    logic [31:0]       vsum_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^mem_readdata;
`endif

    always_comb begin
        state_nxt      = state;
        byte_ready     = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'h0;
        done           = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0 || range_err) state_nxt = S_DONE;
                    else                               state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                byte_ready = 1'b1;
                if (byte_valid && idx_q == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = 4'hF;
                if (last_word) begin
`ifdef MEM_LOADER_VERIFY_EN
                    state_nxt = S_VERIFY;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_FILL;
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            S_VERIFY: begin
                mem_chipselect = 1'b1;
                if (vcnt_q == cnt_q) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
            base_q     <= '0;
            vcnt_q     <= '0;
            vsum_q     <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_q      <= word_count;
                        addr_q     <= base_addr;
                        words_q    <= '0;
                        idx_q      <= '0;
                        checksum_q <= '0;
                        error_q    <= (word_count != '0) && range_err;
`ifdef MEM_LOADER_VERIFY_EN
                        base_q     <= base_addr;
`endif
                    end
                end
                S_FILL: begin
                    if (byte_valid) begin
                        word_q[{idx_q, 3'b000} +: 8] <= byte_data;
                        idx_q                        <= idx_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    checksum_q <= checksum_q + word_q;
                    words_q    <= words_q + ADDR_W'(1);
`ifdef MEM_LOADER_VERIFY_EN
                    // Rewind to the first word so readback starts on the next cycle.
                    if (last_word) begin
                        addr_q <= base_q;
                        vcnt_q <= '0;
                        vsum_q <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
`else
                    addr_q <= addr_q + ADDR_W'(1);
`endif
                end
`ifdef MEM_LOADER_VERIFY_EN
                S_VERIFY: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    vcnt_q <= vcnt_q + ADDR_W'(1);
                    // Read data trails the presented address by one cycle.
                    if (vcnt_q != '0) vsum_q <= vsum_q + mem_readdata;
                    if (vcnt_q == cnt_q && (vsum_q + mem_readdata) != checksum_q) error_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign mem_address   = addr_q;
    assign mem_writedata = word_q;
    assign mem_clken     = 1'b1;
    assign checksum      = checksum_q;
    assign error         = error_q;

endmodule

// File: tb/tb_niosii_onchip_mem_loader.sv
// Directed bench for niosii_onchip_mem_loader: RAM model with write log, per-scenario tasks.
// The readback scenario is compiled only when MEM_LOADER_VERIFY_EN is defined.
module tb_niosii_onchip_mem_loader;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [13:0] base_addr, word_count;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_chipselect, mem_write, mem_clken;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata, checksum;
    logic        busy, done, error;
    logic        force_bit = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:16383];
    logic [13:0] rd_addr = '0;
    int          wr_cnt = 0, acc_cnt = 0, bad_accept = 0;
    logic [13:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];
    logic [3:0]  wr_be_log   [0:63];
    logic [7:0]  stim [0:7];

    niosii_onchip_mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            mem[mem_address] = mem_writedata;
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] = mem_address;
                wr_data_log[wr_cnt] = mem_writedata;
                wr_be_log[wr_cnt]   = mem_byteenable;
            end
            wr_cnt++;
        end
        if (byte_valid && byte_ready) acc_cnt++;
        if (byte_valid && byte_ready && mem_write) bad_accept++;
    end

    always @(posedge clk) rd_addr <= mem_address;
    assign mem_readdata = mem[rd_addr] ^ {31'd0, force_bit};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [13:0] b, input logic [13:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit gap);
        int w;
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = stim[i];
            w = 0;
            while (!byte_ready && w < 20) begin
                tick();
                w++;
            end
            n_checks++;
            if (byte_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_wait byte %0d: byte_ready=%b required 1", i, byte_ready);
            end
            tick();
            if (gap && i != n - 1) begin
                byte_valid = 1'b0;
                tick();
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b required 0", error); end
        n_checks++; if (checksum !== 32'h0) begin n_fail++; $display("FAIL reset_checksum: got %h required 0", checksum); end
        n_checks++; if ({mem_write, mem_chipselect} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_cs: got %b required 00", {mem_write, mem_chipselect}); end
        n_checks++; if (mem_byteenable !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h required 0", mem_byteenable); end
        n_checks++; if (mem_address !== 14'h0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", mem_address); end
        n_checks++; if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h required 0", mem_writedata); end
        n_checks++; if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b required 1", mem_clken); end
        reset = 1'b0;
        tick();
    endtask

    task automatic run_basic(input bit gap, input string tag);
        int w0, a0;
        w0 = wr_cnt;
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) stim[i] = 8'((i + 1) * 8'h11);
        do_start(14'h0010, 14'd2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: got %b required 1", tag, busy); end
        stream(8, gap);
        n_checks++; if (mem_write !== 1'b1 || mem_address !== 14'h0011 || mem_writedata !== 32'h88776655)
            begin n_fail++; $display("FAIL %s_last_write: wr=%b addr=%h data=%h required 1/0011/88776655", tag, mem_write, mem_address, mem_writedata); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b required 1", tag, done); end
        n_checks++; if (checksum !== 32'hCCAA8866) begin n_fail++; $display("FAIL %s_checksum: got %h required ccaa8866", tag, checksum); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL %s_error: got %b required 0", tag, error); end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b done=%b required 0/0", tag, busy, done); end
        n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL %s_write_count: got %0d required 2", tag, wr_cnt - w0); end
        n_checks++; if (wr_addr_log[w0] !== 14'h0010 || wr_data_log[w0] !== 32'h44332211 || wr_be_log[w0] !== 4'hF)
            begin n_fail++; $display("FAIL %s_write0: addr=%h data=%h be=%h required 0010/44332211/f", tag, wr_addr_log[w0], wr_data_log[w0], wr_be_log[w0]); end
        n_checks++; if (wr_addr_log[w0+1] !== 14'h0011 || wr_data_log[w0+1] !== 32'h88776655 || wr_be_log[w0+1] !== 4'hF)
            begin n_fail++; $display("FAIL %s_write1: addr=%h data=%h be=%h required 0011/88776655/f", tag, wr_addr_log[w0+1], wr_data_log[w0+1], wr_be_log[w0+1]); end
        n_checks++; if (acc_cnt - a0 !== 8) begin n_fail++; $display("FAIL %s_accepts: got %0d required 8", tag, acc_cnt - a0); end
        n_checks++; if (bad_accept !== 0) begin n_fail++; $display("FAIL %s_accept_in_write: got %0d required 0", tag, bad_accept); end
    endtask

    task automatic test_range_error();
        int w0;
        w0 = wr_cnt;
        do_start(14'd11999, 14'd2);
        n_checks++; if (busy !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL range_done: busy=%b done=%b required 1/1", busy, done); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL range_error: got %b required 1", error); end
        tick();
        n_checks++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL range_sticky: error=%b busy=%b required 1/0", error, busy); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL range_writes: got %0d required 0", wr_cnt - w0); end
        // Ending exactly at DEPTH is legal.
        do_start(14'd11998, 14'd2);
        n_checks++; if (byte_ready !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL range_edge: ready=%b error=%b required 1/0", byte_ready, error); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = wr_cnt;
        do_start(14'h0020, 14'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL zero_error: got %b required 0", error); end
        tick();
        n_checks++; if (wr_cnt - w0 !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_writes: writes=%0d busy=%b required 0/0", wr_cnt - w0, busy); end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) stim[i] = 8'(8'hA0 + i);
        do_start(14'h0030, 14'd4);
        stream(6, 1'b0);
        n_checks++; if (checksum !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL midrst_partial_sum: got %h required a3a2a1a0", checksum); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy=%b ready=%b required 0/0", busy, byte_ready); end
        n_checks++; if (checksum !== 32'h0) begin n_fail++; $display("FAIL midrst_checksum: got %h required 0", checksum); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL midrst_writes: got %0d required 1", wr_cnt - w0); end
        n_checks++; if (mem[14'h0030] !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL midrst_mem: got %h required a3a2a1a0", mem[14'h0030]); end
        tick();
    endtask

    task automatic test_back_to_back();
        stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE; stim[3] = 8'hEF;
        do_start(14'd11999, 14'd1);
        stream(4, 1'b0);
        n_checks++; if (mem_address !== 14'd11999 || mem_writedata !== 32'hEFBEADDE)
            begin n_fail++; $display("FAIL b2b_write: addr=%0d data=%h required 11999/efbeadde", mem_address, mem_writedata); end
        tick();
        n_checks++; if (done !== 1'b1 || checksum !== 32'hEFBEADDE) begin n_fail++; $display("FAIL b2b_done: done=%b sum=%h required 1/efbeadde", done, checksum); end
        base_addr  = 14'h0050;
        word_count = 14'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_ignored: busy=%b required 0", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stays_idle: busy=%b required 0", busy); end
    endtask

`ifdef MEM_LOADER_VERIFY_EN
    task automatic run_verify(input bit flip, input logic exp_err);
        int w;
        force_bit = 1'b0;
        for (int i = 0; i < 8; i++) stim[i] = 8'((i + 1) * 8'h11);
        do_start(14'h0010, 14'd2);
        stream(8, 1'b0);
        force_bit = flip;
        w = 0;
        while (!done && w < 20) begin
            tick();
            w++;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL verify_done: got %b required 1", done); end
        n_checks++; if (error !== exp_err) begin n_fail++; $display("FAIL verify_error flip=%b: got %b required %b", flip, error, exp_err); end
        force_bit = 1'b0;
        tick();
    endtask

    task automatic test_verify();
        run_verify(1'b0, 1'b0);
        run_verify(1'b1, 1'b1);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        base_addr  = '0;
        word_count = '0;
        test_reset();
`ifdef MEM_LOADER_VERIFY_EN
        test_verify();
`else
        run_basic(1'b0, "basic");
        run_basic(1'b1, "backpressure");
        test_range_error();
        test_zero_count();
        test_reset_mid_load();
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
